// File: rtl/spmv_index_val_join_pkg.sv
// Shared types and defaults for the SpMV index/value join stage.
package spmv_join_pkg;

  localparam int IDX_W_DEF = 32;
  localparam int VAL_W_DEF = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [IDX_W_DEF-1:0] row;
    logic [IDX_W_DEF-1:0] col;
    logic [VAL_W_DEF-1:0] val;
  } triple_t;

endpackage

// File: rtl/spmv_index_val_join_if.sv
// Stream bundle between the decoder, the join stage and the MAC consumer.
// slave = the join stage, master = whoever drives pushes and takes triples.
interface spmv_index_val_join_if
  import spmv_join_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int VAL_W = VAL_W_DEF
);
  logic             push_index;
  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;
  logic             stall_index;
  logic             push_val;
  logic [VAL_W-1:0] val;
  logic             stall_val;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_row;
  logic [IDX_W-1:0] out_col;
  logic [VAL_W-1:0] out_val;
  logic             out_last;

  modport slave (
    input  push_index, row, col, push_val, val, out_ready,
    output stall_index, stall_val, out_valid, out_row, out_col, out_val, out_last
  );

  modport master (
    output push_index, row, col, push_val, val, out_ready,
    input  stall_index, stall_val, out_valid, out_row, out_col, out_val, out_last
  );
endinterface

// File: rtl/spmv_stream_fifo.sv
// First-word-fall-through FIFO with registered storage. The head reads as
// zero while empty so downstream data outputs are clean after reset.
module spmv_stream_fifo
  import spmv_join_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      occupancy,
  output logic             full,
  output logic             empty,
  output logic             overflow_pulse
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             wr_en;
  logic             rd_en;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  // A pop frees the slot in the same edge, so push-on-full with pop is legal.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign overflow_pulse = push & full & ~pop;
  assign occupancy = cnt;
  assign dout = empty ? '0 : mem[rd_ptr];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      cnt <= cnt + 1'b1;
      else if (!wr_en && rd_en) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spmv_index_val_join.sv
// Joins the decoder's index and value streams into ordered (row, col, val)
// triples, counts them per matrix run and flags the final one.
module spmv_index_val_join
  import spmv_join_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STALL_SLACK = 6,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int VAL_W       = VAL_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [31:0]                 last_idx,
  spmv_index_val_join_if.slave        s,
  output logic                        busy,
  output logic                        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - STALL_SLACK);

  state_t             state_q;
  state_t             state_d;
  logic [31:0]        count_q;
  logic [31:0]        last_q;
  logic               stall_index_q;
  logic               stall_val_q;
  logic               overflow_q;
  logic               handshake;

  logic [2*IDX_W-1:0] idx_head;
  logic [VAL_W-1:0]   val_head;
  logic [AW:0]        idx_occ;
  logic [AW:0]        val_occ;
  logic               idx_full;
  logic               val_full;
  logic               idx_empty;
  logic               val_empty;
  logic               idx_ovf;
  logic               val_ovf;
  logic               unused_full;

  spmv_stream_fifo #(.WIDTH(2*IDX_W), .DEPTH(DEPTH)) u_idx_fifo (
    .clk            (clk),
    .rst_n          (rst_n),
    .push           (s.push_index),
    .din            ({s.row, s.col}),
    .pop            (handshake),
    .dout           (idx_head),
    .occupancy      (idx_occ),
    .full           (idx_full),
    .empty          (idx_empty),
    .overflow_pulse (idx_ovf)
  );

  spmv_stream_fifo #(.WIDTH(VAL_W), .DEPTH(DEPTH)) u_val_fifo (
    .clk            (clk),
    .rst_n          (rst_n),
    .push           (s.push_val),
    .din            (s.val),
    .pop            (handshake),
    .dout           (val_head),
    .occupancy      (val_occ),
    .full           (val_full),
    .empty          (val_empty),
    .overflow_pulse (val_ovf)
  );

  // Full flags are folded into the FIFOs' own accept/overflow logic.
  assign unused_full = idx_full & val_full;

  assign s.out_valid   = (state_q == RUN) & ~idx_empty & ~val_empty;
  assign s.out_row     = idx_head[2*IDX_W-1:IDX_W];
  assign s.out_col     = idx_head[IDX_W-1:0];
  assign s.out_val     = val_head;
  assign s.out_last    = s.out_valid & (count_q == last_q);
  assign s.stall_index = stall_index_q;
  assign s.stall_val   = stall_val_q;
  assign handshake     = s.out_valid & s.out_ready;
  assign busy          = (state_q == RUN);
  assign overflow      = overflow_q;

  // Run control: arm on start, close out on the handshake of the last triple.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (handshake && s.out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, triple counter, registered stalls and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      last_q        <= '0;
      stall_index_q <= 1'b0;
      stall_val_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        count_q <= '0;
        last_q  <= last_idx;
      end else if (handshake) begin
        count_q <= count_q + 32'd1;
      end
      stall_index_q <= (idx_occ >= STALL_TH);
      stall_val_q   <= (val_occ >= STALL_TH);
      overflow_q    <= overflow_q | idx_ovf | val_ovf;
    end
  end

endmodule

// File: doc/spmv_index_val_join.md
Name: spmv_index_val_join

Overview:
- Downstream stage of sparse_matrix_decoder. Consumes its two independent output streams:
  - index stream: push_index, row, col, with stall_index
  - value stream: push_val, val, with stall_val
- Buffers each stream in its own FIFO and pairs them in order into one (row, col, val) triple stream with a valid/ready handshake.
- Counts the triples it emits and flags the last non-zero so the SpMV multiply-accumulate stage can close out a matrix.

Parameters:
- DEPTH, 16: entries per FIFO; must be a power of two and at least 8.
- STALL_SLACK, 6: free entries that must remain when stall_* asserts. Covers the 1-cycle stall register plus decoder in-flight pushes.
- IDX_W, 32: width of row and col.
- VAL_W, 64: width of val (IEEE double bits).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  1-cycle pulse; arms a matrix run.
- last_idx  in  32  nnz-1; sampled on start.
- push_index  in  1  index word valid.
- row  in  IDX_W  row index.
- col  in  IDX_W  column index.
- stall_index  out  1  back-pressure to decoder index path.
- push_val  in  1  value word valid.
- val  in  VAL_W  value bits.
- stall_val  out  1  back-pressure to decoder value path.
- out_valid  out  1  triple available.
- out_ready  in  1  consumer accepts.
- out_row  out  IDX_W  paired row.
- out_col  out  IDX_W  paired col.
- out_val  out  VAL_W  paired value.
- out_last  out  1  this triple is number last_idx (the final one).
- busy  out  1  run armed, final triple not yet taken.
- overflow  out  1  sticky error: a push arrived while that FIFO was full.

Behaviour:
- Reset (async, rst_n low), all outputs and state go to:
  - both FIFOs empty
  - busy=0, count=0, out_valid=0, out_last=0
  - stall_index=0, stall_val=0, overflow=0
  - out_row/out_col/out_val=0
- States: IDLE, RUN.
  - IDLE -> RUN on start. Latches last_idx and clears count.
  - RUN -> IDLE on the handshake (out_valid & out_ready) that carries out_last.
  - start while in RUN is ignored.
- busy=1 exactly in RUN.
- FIFO writes:
  - Happen on push_* in any state. Pushes in IDLE are buffered, not dropped.
  - A push to a full FIFO is discarded and sets overflow. overflow clears only on reset.
  - Simultaneous push and pop on a full FIFO is legal, is accepted, and does not set overflow.
- Stall:
  - Registered: stall_x(N+1) = (occupancy_x(N) >= DEPTH-STALL_SLACK).
  - Deasserts the cycle after occupancy drops below the threshold.
- Output:
  - out_valid = RUN & index FIFO non-empty & value FIFO non-empty.
  - out_row/out_col/out_val are the FIFO heads (first-word-fall-through from registered storage).
  - Data pushed at edge N is visible at the head from cycle N+1. Minimum push-to-out_valid latency is 1 cycle.
  - A handshake pops both FIFOs at the same edge and increments count.
  - out_last = out_valid & (count == latched last_idx).
  - Held outputs stay stable while out_valid & !out_ready.
- Pairing is strictly FIFO order. The k-th index word joins the k-th value word; no reordering.
- Count is 32-bit.
  - last_idx=0 means a single triple.
  - Triples beyond last_idx stay buffered for the next run.
- Reset mid-run discards all buffered data and returns to IDLE immediately.

Decomposition:
- Package spmv_join_pkg holds:
  - IDX_W, VAL_W defaults
  - the state encoding (IDLE=0, RUN=1)
  - a packed triple type {row, col, val}
- Sub-module spmv_stream_fifo: parameterised width/depth FWFT FIFO. Provides occupancy output, full/empty, and an overflow pulse. Instantiated twice (index width 2*IDX_W, value width VAL_W).
- The join FSM, counter, and stall registers live in the top.

Test Plan:
- Reset then start with last_idx=2. Push index (0,1),(0,3),(2,2) and val 1.0, 2.5, -4.0 on the same cycles, with out_ready=1.
  - Expect 3 triples in order, first at 1 cycle after the first push.
  - out_last only on (2,2,-4.0); busy falls after it.
- Index pushes 4 cycles ahead of values.
  - Expect out_valid=0 until the first value arrives, then correct pairing.
- Hold out_ready=0 and push continuously.
  - Expect stall_* to assert the cycle after occupancy reaches 10 (DEPTH=16, SLACK=6).
  - Expect overflow to remain 0 when the driver stops within 6 cycles.
- Hold out_ready=0 and push 17 index words.
  - Expect the 17th to be dropped and overflow=1 (sticky).
  - After releasing out_ready, exactly 16 index words are drained.
- Start with last_idx=0, push 2 pairs.
  - Expect one triple with out_last=1, then busy=0.
  - Second pair held; a new start emits it immediately.
- Drop rst_n mid-run with 5 entries buffered.
  - Expect out_valid=0, busy=0, stall=0 asynchronously, and FIFOs empty after release.
